// File: rtl/pc_gen_unit.sv
// pc_gen_unit
//   Program-counter generator for the fetch stage. Produces the instruction
//   fetch address and its valid qualifier, steps sequentially by INST_BYTES,
//   and takes trap and branch redirects in priority order. A redirect that
//   arrives while fetch is held is parked in a pending register and applied
//   on the first cycle the fetch can advance. Held cycles are counted in a
//   saturating counter.
//
// Ports
//   clk               clock, rising edge
//   rst               asynchronous active-low reset
//   stall             pipeline hold from the hazard unit
//   fetch_ready       instruction memory accepts an address this cycle
//   redirect_valid    branch/jump resolved taken
//   redirect_pc       branch/jump target
//   trap_valid        exception/interrupt redirect (highest priority)
//   trap_pc           trap handler address
//   pc                current fetch address
//   pc_valid          pc is a valid fetch request
//   redirect_pending  a redirect is latched and not yet applied
//   flush             one-cycle pulse after a redirect/trap was applied
//   misalign          one-cycle pulse, with flush, when the applied target
//                     had its low alignment bits set
//   stall_cnt         saturating count of held cycles
//
// State        | meaning
// -------------+-----------------------------------------------------------
// BOOT         | first cycle after reset release, no fetch issued
// RUN          | normal fetch, no redirect waiting
// HOLD_REDIR   | fetch held with a redirect target parked in pend_pc

module pc_gen_unit #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INST_BYTES   = 4,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_pc,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic             redirect_pending,
    output logic             flush,
    output logic             misalign,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        HOLD_REDIR = 2'd2
    } state_t;

    // Low bits that must be zero in any fetch address.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);

    state_t           state;
    logic [XLEN-1:0]  pend_pc;

    logic             advance;
    logic             hold_cycle;
    logic             cnt_sat;
    logic [XLEN-1:0]  trap_tgt;
    logic [XLEN-1:0]  redir_tgt;
    logic [XLEN-1:0]  pend_tgt;
    logic             trap_mis;
    logic             redir_mis;
    logic             pend_mis;

    assign advance    = pc_valid & ~stall & fetch_ready;
    // A trap moves the PC even when held, so that cycle is not counted.
    assign hold_cycle = pc_valid & ~advance & ~trap_valid;
    assign cnt_sat    = &stall_cnt;

    assign trap_tgt   = trap_pc     & ~ALIGN_MASK;
    assign redir_tgt  = redirect_pc & ~ALIGN_MASK;
    assign pend_tgt   = pend_pc     & ~ALIGN_MASK;
    assign trap_mis   = |(trap_pc     & ALIGN_MASK);
    assign redir_mis  = |(redirect_pc & ALIGN_MASK);
    // The raw target is parked so misalignment is flagged when it is applied.
    assign pend_mis   = |(pend_pc     & ALIGN_MASK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= BOOT;
            pc               <= RESET_VECTOR;
            pc_valid         <= 1'b0;
            pend_pc          <= '0;
            redirect_pending <= 1'b0;
            flush            <= 1'b0;
            misalign         <= 1'b0;
            stall_cnt        <= '0;
        end else begin
            flush    <= 1'b0;
            misalign <= 1'b0;

            if (hold_cycle && !cnt_sat) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            case (state)
                BOOT: begin
                    // Redirects and traps are ignored until fetch is live.
                    state            <= RUN;
                    pc_valid         <= 1'b1;
                    redirect_pending <= 1'b0;
                end

                default: begin
                    if (trap_valid) begin
                        pc               <= trap_tgt;
                        pend_pc          <= '0;
                        state            <= RUN;
                        redirect_pending <= 1'b0;
                        flush            <= 1'b1;
                        misalign         <= trap_mis;
                    end else if (redirect_valid && advance) begin
                        pc               <= redir_tgt;
                        pend_pc          <= '0;
                        state            <= RUN;
                        redirect_pending <= 1'b0;
                        flush            <= 1'b1;
                        misalign         <= redir_mis;
                    end else if (redirect_valid) begin
                        // Newest redirect wins over any older parked target.
                        pend_pc          <= redirect_pc;
                        state            <= HOLD_REDIR;
                        redirect_pending <= 1'b1;
                    end else if (state == HOLD_REDIR && advance) begin
                        pc               <= pend_tgt;
                        pend_pc          <= '0;
                        state            <= RUN;
                        redirect_pending <= 1'b0;
                        flush            <= 1'b1;
                        misalign         <= pend_mis;
                    end else if (advance) begin
                        pc <= pc + PC_STEP;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             stall;
    logic             fetch_ready;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             trap_valid;
    logic [XLEN-1:0]  trap_pc;
    logic [XLEN-1:0]  pc;
    logic             pc_valid;
    logic             redirect_pending;
    logic             flush;
    logic             misalign;
    logic [CNT_W-1:0] stall_cnt;

    int n_vec;
    int n_err;

    pc_gen_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (64'h1000),
        .INST_BYTES   (4),
        .CNT_W        (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .fetch_ready      (fetch_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .trap_valid       (trap_valid),
        .trap_pc          (trap_pc),
        .pc               (pc),
        .pc_valid         (pc_valid),
        .redirect_pending (redirect_pending),
        .flush            (flush),
        .misalign         (misalign),
        .stall_cnt        (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst            = 1'b0;
        stall          = 1'b0;
        fetch_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_valid     = 1'b0;
        trap_pc        = '0;

        #12;
        chk("rst_pc",       pc,               64'h1000);
        chk("rst_valid",    pc_valid,         0);
        chk("rst_pending",  redirect_pending, 0);
        chk("rst_flush",    flush,            0);
        chk("rst_misalign", misalign,         0);
        chk("rst_cnt",      stall_cnt,        0);

        // Release; a trap during BOOT must be ignored.
        rst        = 1'b1;
        trap_valid = 1'b1;
        trap_pc    = 64'h8000;
        #1;
        chk("boot_pc",    pc,       64'h1000);
        chk("boot_valid", pc_valid, 0);
        tick();
        trap_valid = 1'b0;
        chk("run0_pc",    pc,       64'h1000);
        chk("run0_valid", pc_valid, 1);
        chk("run0_flush", flush,    0);
        tick();
        chk("seq1_pc", pc, 64'h1004);
        tick();
        chk("seq2_pc", pc, 64'h1008);
        chk("seq_cnt", stall_cnt, 0);

        // Wrap at the top of the address space.
        trap_valid = 1'b1;
        trap_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        trap_valid = 1'b0;
        chk("top_pc",    pc,    64'hFFFF_FFFF_FFFF_FFFC);
        chk("top_flush", flush, 1);
        tick();
        chk("wrap_pc",    pc,    64'h0);
        chk("wrap_flush", flush, 0);

        // Redirect while stalled for three cycles.
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        for (int i = 1; i <= 3; i++) begin
            tick();
            redirect_valid = 1'b0;
            chk("hold_pending", redirect_pending, 1);
            chk("hold_pc",      pc,               64'h0);
            chk("hold_cnt",     stall_cnt,        64'(i));
            chk("hold_flush",   flush,            0);
        end
        stall = 1'b0;
        tick();
        chk("apply_pc",      pc,               64'h2000);
        chk("apply_flush",   flush,            1);
        chk("apply_pending", redirect_pending, 0);
        tick();
        chk("after_pc",    pc,    64'h2004);
        chk("after_flush", flush, 0);

        // Newer pending redirect overwrites the older one.
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        tick();
        redirect_pc    = 64'h3000;
        tick();
        chk("ovw_hold_pc", pc,        64'h2004);
        chk("ovw_cnt",     stall_cnt, 5);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        tick();
        chk("ovw_pc",    pc,    64'h3000);
        chk("ovw_flush", flush, 1);

        // Trap beats a same-cycle redirect, even when stalled.
        stall          = 1'b1;
        trap_valid     = 1'b1;
        trap_pc        = 64'h8000;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        tick();
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        chk("trap_pc",      pc,               64'h8000);
        chk("trap_pending", redirect_pending, 0);
        chk("trap_flush",   flush,            1);
        chk("trap_cnt",     stall_cnt,        5);
        stall = 1'b0;
        tick();
        chk("trap_next_pc", pc, 64'h8004);

        // Misaligned redirect while advancing.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2002;
        tick();
        redirect_valid = 1'b0;
        chk("mis_pc",       pc,       64'h2000);
        chk("mis_misalign", misalign, 1);
        chk("mis_flush",    flush,    1);
        tick();
        chk("mis_next_pc", pc,       64'h2004);
        chk("mis_clear",   misalign, 0);

        // Memory not ready holds the PC and counts.
        fetch_ready = 1'b0;
        tick();
        chk("nrdy_pc",  pc,        64'h2004);
        chk("nrdy_cnt", stall_cnt, 6);
        fetch_ready = 1'b1;

        // Counter saturates at 15.
        stall = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("sat_cnt", stall_cnt, 15);
        chk("sat_pc",  pc,        64'h2004);

        // Reset mid-stall takes effect without a clock edge.
        rst = 1'b0;
        #1;
        chk("mrst_pc",    pc,        64'h1000);
        chk("mrst_cnt",   stall_cnt, 0);
        chk("mrst_valid", pc_valid,  0);
        rst   = 1'b1;
        stall = 1'b0;
        tick();
        tick();
        chk("mrst_run_pc", pc, 64'h1004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Parametrised program-counter generator for the fetch stage. It is the next generation of the single-register PC with stall: configurable width, reset vector and instruction size, and an on-chip sequential incrementer. It adds prioritised trap and branch redirects, a pending-redirect latch for redirects that arrive while the PC is held, and a saturating stall counter. It drives the instruction-memory address and the fetch-valid qualifier.

Parameters:
XLEN, 64, PC and target width in bits
RESET_VECTOR, 0, PC value loaded on reset
INST_BYTES, 4, sequential increment; power of two, 2 or 4
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  pipeline hold from hazard unit
fetch_ready  in  1  instruction memory accepts an address this cycle
redirect_valid  in  1  branch/jump resolved taken
redirect_pc  in  XLEN  branch/jump target
trap_valid  in  1  exception/interrupt redirect
trap_pc  in  XLEN  trap handler address
pc  out  XLEN  current fetch address
pc_valid  out  1  pc is a valid fetch request
redirect_pending  out  1  a redirect is latched and not yet applied
flush  out  1  one-cycle pulse: a redirect or trap was applied last edge
misalign  out  1  one-cycle pulse: the applied target had low bits set
stall_cnt  out  CNT_W  saturating count of held cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_VECTOR, pc_valid=0.
  - redirect_pending=0, pending target cleared.
  - flush=0, misalign=0, stall_cnt=0.
  - State=BOOT.
- States: BOOT, RUN, HOLD_REDIR.
- BOOT: lasts exactly one cycle after reset release. pc stays at RESET_VECTOR, pc_valid=0. Next state is RUN with pc_valid=1. A trap_valid or redirect_valid in BOOT is ignored.
- advance = pc_valid & ~stall & fetch_ready.
- Next-PC priority, evaluated each edge in RUN or HOLD_REDIR:
  1. trap_valid: pc<=trap_pc regardless of stall or fetch_ready. Clears any pending target. Next state is RUN.
  2. redirect_valid & advance: pc<=redirect_pc. Clears pending. Next state is RUN.
  3. redirect_valid & ~advance: latch redirect_pc into the pending register, which overwrites any older pending target. pc holds. Next state is HOLD_REDIR.
  4. HOLD_REDIR & advance: pc<=pending target. Clears pending. Next state is RUN.
  5. advance: pc<=pc+INST_BYTES, modulo 2^XLEN. Wraps from all-ones-aligned to 0 with no flag.
  6. Otherwise pc holds.
- redirect_pending = (state==HOLD_REDIR), registered.
- flush pulses high for one cycle after any edge that applied case 1, 2 or 4.
- Alignment: every applied target (cases 1, 2, 4) has its low log2(INST_BYTES) bits forced to 0. misalign pulses for one cycle, coincident with flush, when any of those bits were 1.
- stall_cnt: increments by 1 on each edge where pc_valid & ~advance & ~trap_valid. Saturates at 2^CNT_W-1. Cleared only by reset.
- Reset asserted mid-operation overrides everything immediately. There is no partial update.
- All outputs are registered. Output latency from an input to pc is one edge.

Test Plan:
- Reset release, stall=0, fetch_ready=1, RESET_VECTOR=0x1000, INST_BYTES=4 -> cycle 0: pc=0x1000, pc_valid=0; then pc_valid=1 and pc=0x1000, 0x1004, 0x1008 on successive edges.
- Wrap: force pc to 0xFFFF_FFFF_FFFF_FFFC, advance once -> pc=0, no flush.
- redirect_valid with redirect_pc=0x2000 while stall=1 for 3 cycles:
  - redirect_pending=1 and pc held for those 3 cycles, stall_cnt +3.
  - On the first edge with stall=0, pc=0x2000 and flush pulses once.
  - Then pc=0x2004.
- Pending overwrite: redirect 0x2000 while stalled, then redirect 0x3000 while still stalled, then release -> pc=0x3000, never 0x2000.
- Trap priority: trap_valid with trap_pc=0x8000 and redirect_valid with 0x2000 in the same cycle while stall=1 -> pc=0x8000 next edge, redirect_pending=0, flush=1.
- Misaligned target: redirect_pc=0x2002 with INST_BYTES=4, advancing -> pc=0x2000, misalign=1 and flush=1 for one cycle. Also assert rst mid-stall -> pc=RESET_VECTOR immediately and stall_cnt=0.
